// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter unit.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } pc_state_t;

  localparam int unsigned DEFAULT_INSTR_BYTES = 4;

  // Shift that turns a word offset into a byte offset.
  function automatic int unsigned log2_bytes(input int unsigned bytes);
    return $clog2(bytes);
  endfunction

  localparam int unsigned INSTR_SHIFT = log2_bytes(DEFAULT_INSTR_BYTES);

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h8000_0180;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC arithmetic: sequential increment, branch target,
// aligned jump target, and jump-over-branch target selection.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned INSTR_BYTES = DEFAULT_INSTR_BYTES
) (
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] branch_offset,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             jump,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] redirect_target
);

  localparam int unsigned      SHIFT      = log2_bytes(INSTR_BYTES);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(INSTR_BYTES - 1);

  logic [WIDTH-1:0] branch_target;
  logic [WIDTH-1:0] jump_aligned;

  // All sums wrap modulo 2^WIDTH; a jump always beats a branch.
  always_comb begin
    pc_plus4        = pc + WIDTH'(INSTR_BYTES);
    branch_target   = pc_plus4 + (branch_offset << SHIFT);
    jump_aligned    = jump_target & ALIGN_MASK;
    redirect_target = jump ? jump_aligned : branch_target;
  end

endmodule

// File: rtl/pc_unit.sv
// Clocked program counter with stall hold, latched redirect during stall,
// exception vectoring and IF/ID flush pulse.
// Optional macro PC_MISALIGN_CHECK_EN: misaligned jump targets vector to
// EXC_VECTOR and pulse the extra 'misalign' output.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEFAULT_EXC_VECTOR),
  parameter int unsigned      INSTR_BYTES  = DEFAULT_INSTR_BYTES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_offset,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             exception,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             valid,
  output logic             flush,
  output logic             pending
`ifdef PC_MISALIGN_CHECK_EN
  ,
  output logic             misalign
`endif
);

  pc_state_t        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             valid_q, valid_d;
  logic             flush_q, flush_d;
  logic             pending_q, pending_d;
  logic [WIDTH-1:0] redirect_target;
  logic             redirect;

`ifdef PC_MISALIGN_CHECK_EN
  localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(INSTR_BYTES - 1);
  logic misalign_q, misalign_d;
  logic pend_mis_q, pend_mis_d;
  logic jump_mis;
  assign jump_mis = (jump_target & LOW_MASK) != '0;
`endif

  pc_next_sel #(
    .WIDTH       (WIDTH),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_next_sel (
    .pc              (pc_q),
    .branch_offset   (branch_offset),
    .jump_target     (jump_target),
    .jump            (jump),
    .pc_plus4        (pc_plus4),
    .redirect_target (redirect_target)
  );

  assign redirect = jump | branch_taken;

  // Next-state and next-register values; flush/misalign default low so they pulse.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    target_d  = target_q;
    valid_d   = valid_q;
    flush_d   = 1'b0;
    pending_d = pending_q;
`ifdef PC_MISALIGN_CHECK_EN
    misalign_d = 1'b0;
    pend_mis_d = pend_mis_q;
`endif
    case (state_q)
      BOOT: begin
        valid_d = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (exception) begin
          pc_d    = EXC_VECTOR;
          flush_d = 1'b1;
        end else if (redirect && !stall) begin
          flush_d = 1'b1;
          pc_d    = redirect_target;
`ifdef PC_MISALIGN_CHECK_EN
          if (jump && jump_mis) begin
            pc_d       = EXC_VECTOR;
            misalign_d = 1'b1;
          end
`endif
        end else if (redirect) begin
          target_d  = redirect_target;
          pending_d = 1'b1;
          state_d   = PEND;
`ifdef PC_MISALIGN_CHECK_EN
          pend_mis_d = jump && jump_mis;
`endif
        end else if (!stall) begin
          pc_d = pc_plus4;
        end
      end
      PEND: begin
        if (exception || !stall) begin
          flush_d   = 1'b1;
          pending_d = 1'b0;
          state_d   = RUN;
          pc_d      = exception ? EXC_VECTOR : target_q;
`ifdef PC_MISALIGN_CHECK_EN
          // The misalignment of a latched jump is only acted on at release.
          if (!exception && pend_mis_q) begin
            pc_d       = EXC_VECTOR;
            misalign_d = 1'b1;
          end
          pend_mis_d = 1'b0;
`endif
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= BOOT;
      pc_q      <= RESET_VECTOR;
      target_q  <= '0;
      valid_q   <= 1'b0;
      flush_q   <= 1'b0;
      pending_q <= 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
      pend_mis_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      target_q  <= target_d;
      valid_q   <= valid_d;
      flush_q   <= flush_d;
      pending_q <= pending_d;
`ifdef PC_MISALIGN_CHECK_EN
      misalign_q <= misalign_d;
      pend_mis_q <= pend_mis_d;
`endif
    end
  end

  assign pc      = pc_q;
  assign valid   = valid_q;
  assign flush   = flush_q;
  assign pending = pending_q;
`ifdef PC_MISALIGN_CHECK_EN
  assign misalign = misalign_q;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus random stimulus
// against a behavioural reference model.
module tb_pc_unit;

  localparam logic [31:0] RST_VEC = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC = 32'h8000_0180;
`ifdef PC_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_offset = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        exception = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        valid;
  logic        flush;
  logic        pending;
  logic        misalign;

  pc_unit #(
    .WIDTH        (32),
    .RESET_VECTOR (RST_VEC),
    .EXC_VECTOR   (EXC_VEC),
    .INSTR_BYTES  (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_target   (jump_target),
    .exception     (exception),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .valid         (valid),
    .flush         (flush),
    .pending       (pending)
`ifdef PC_MISALIGN_CHECK_EN
    ,
    .misalign      (misalign)
`endif
  );

`ifndef PC_MISALIGN_CHECK_EN
  assign misalign = 1'b0;
`endif

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model state.
  logic [31:0] m_pc, m_target;
  bit m_boot, m_valid, m_flush, m_pending, m_mis, m_pmis;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("pc", pc, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    check("valid", 32'(valid), 32'(m_valid));
    check("flush", 32'(flush), 32'(m_flush));
    check("pending", 32'(pending), 32'(m_pending));
    check("misalign", 32'(misalign), 32'(m_mis));
  endtask

  task automatic model_reset();
    m_pc = RST_VEC; m_target = '0;
    m_boot = 1; m_valid = 0; m_flush = 0; m_pending = 0; m_mis = 0; m_pmis = 0;
  endtask

  // One clock of the behavioural rules, using the current inputs.
  task automatic model_step();
    logic [31:0] tgt;
    bit tgt_mis;
    m_flush = 0;
    m_mis = 0;
    if (m_boot) begin
      m_boot = 0;
      m_valid = 1;
    end else if (m_pending) begin
      if (exception) begin
        m_pc = EXC_VEC; m_flush = 1; m_pending = 0; m_pmis = 0;
      end else if (!stall) begin
        m_flush = 1; m_pending = 0;
        if (m_pmis) begin m_pc = EXC_VEC; m_mis = 1; end
        else m_pc = m_target;
        m_pmis = 0;
      end
    end else begin
      if (jump) begin
        tgt = {jump_target[31:2], 2'b00};
        tgt_mis = MIS_EN && (jump_target[1:0] != 2'b00);
      end else begin
        tgt = m_pc + 32'd4 + branch_offset * 32'd4;
        tgt_mis = 0;
      end
      if (exception) begin
        m_pc = EXC_VEC; m_flush = 1;
      end else if ((jump || branch_taken) && !stall) begin
        m_flush = 1;
        m_pc = tgt_mis ? EXC_VEC : tgt;
        m_mis = tgt_mis;
      end else if (jump || branch_taken) begin
        m_pending = 1; m_target = tgt; m_pmis = tgt_mis;
      end else if (!stall) begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic set_in(input bit st, input bit br, input logic [31:0] off,
                        input bit jp, input logic [31:0] jt, input bit ex);
    stall = st; branch_taken = br; branch_offset = off;
    jump = jp; jump_target = jt; exception = ex;
  endtask

  // Asynchronous reset: outputs must clear without any clock edge.
  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_pc", pc, RST_VEC);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic idle();
    set_in(0, 0, '0, 0, '0, 0);
  endtask

  initial begin
    model_reset();
    #2;
    do_reset();

    // Boot cycle, then sequential fetch 0,4,8,...
    idle();
    step(); check("boot_pc", pc, 32'h0); check("boot_valid", 32'(valid), 32'd1);
    step(); check("seq_pc4", pc, 32'h4);
    step(); check("seq_pc8", pc, 32'h8);
    step(); step(); check("seq_pc10", pc, 32'h10);

    // Backward branch.
    set_in(0, 1, 32'hFFFF_FFFE, 0, '0, 0);
    step(); check("br_pc", pc, 32'h0C); check("br_flush", 32'(flush), 32'd1);
    idle();
    step(); check("br_flush_off", 32'(flush), 32'd0);

    // Stalled jump held for three cycles, then released.
    set_in(0, 0, '0, 1, 32'h20, 0);
    step();
    set_in(1, 0, '0, 1, 32'h400, 0);
    step(); check("stj_pc", pc, 32'h20); check("stj_pend", 32'(pending), 32'd1);
    set_in(1, 1, 32'h100, 1, 32'h800, 0);
    step(); step(); check("stj_hold", pc, 32'h20);
    idle();
    step(); check("stj_rel_pc", pc, 32'h400); check("stj_rel_flush", 32'(flush), 32'd1);
    check("stj_rel_pend", 32'(pending), 32'd0);

    // Exception beats stall and jump.
    set_in(0, 0, '0, 1, 32'h40, 0);
    step();
    set_in(1, 0, '0, 1, 32'h900, 1);
    step(); check("exc_pc", pc, EXC_VEC); check("exc_pend", 32'(pending), 32'd0);

    // Exception discards a latched target.
    set_in(1, 1, 32'h8, 0, '0, 0);
    step();
    set_in(1, 0, '0, 0, '0, 1);
    step(); check("pexc_pc", pc, EXC_VEC);
    idle(); step();

    // Jump and branch together: jump wins. Then wrap at the top.
    set_in(0, 1, 32'h10, 1, 32'hFFFF_FFFC, 0);
    step(); check("wrap_jpc", pc, 32'hFFFF_FFFC);
    idle();
    step(); check("wrap_pc", pc, 32'h0);

    // Misaligned jump target, direct and latched.
    set_in(0, 0, '0, 1, 32'h402, 0);
    step(); check("mis_pc", pc, MIS_EN ? EXC_VEC : 32'h400);
    check("mis_flag", 32'(misalign), 32'(MIS_EN));
    idle(); step(); check("mis_flag_off", 32'(misalign), 32'd0);
    set_in(1, 0, '0, 1, 32'h603, 0);
    step();
    idle();
    step(); check("pmis_pc", pc, MIS_EN ? EXC_VEC : 32'h600);

    // Random traffic with occasional mid-run resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      set_in($urandom_range(0, 9) < 3,
             $urandom_range(0, 9) < 2,
             ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 63)) - 32'd32,
             $urandom_range(0, 9) == 0,
             32'($urandom) & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC),
             $urandom_range(0, 39) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
